// File: rtl/core_l1_router.sv
// ============================================================================
// Module   : core_l1_router
// Brief    : Routes single outstanding core requests to split L1I/L1D caches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_l1_router #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                OFFSET_W   = 6,
    parameter int                INDEX_W    = 5,
    parameter int                TAG_W      = ADDR_W - INDEX_W - OFFSET_W,
    parameter logic [ADDR_W-1:0] IMEM_LIMIT = 32'h1000_0000,
    parameter int                TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_wstrb,
    output logic                 req_ready,
    output logic                 stall,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [DATA_W-1:0]    read_data_L1_C,
    output logic [TAG_W-1:0]     tag_C_L1,
    output logic [INDEX_W-1:0]   index_C_L1,
    output logic [OFFSET_W-1:0]  offset,
    output logic                 read_C_L1I,
    output logic                 read_C_L1D,
    output logic                 write_C_L1D,
    output logic [DATA_W-1:0]    write_data_C_L1D,
    output logic [DATA_W/8-1:0]  write_strb_C_L1D,
    input  logic                 stall_L1I,
    input  logic                 stall_L1D,
    input  logic [DATA_W-1:0]    read_data_L1I_C,
    input  logic [DATA_W-1:0]    read_data_L1D_C
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ_I = 2'd1,
        S_REQ_D = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                sel_stall;
    logic [DATA_W-1:0]   sel_data;

    // Only the cache owning the current request is observed.
    assign sel_stall = (state_q == S_REQ_I) ? stall_L1I : stall_L1D;
    assign sel_data  = (state_q == S_REQ_I) ? read_data_L1I_C : read_data_L1D_C;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    wr_d    = req_write;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (req_addr <= IMEM_LIMIT) begin
                        if (req_write) begin
                            // Instruction region is read-only: answer with an error, no cache access.
                            err_d   = 1'b1;
                            rdata_d = '0;
                            state_d = S_RESP;
                        end else begin
                            state_d = S_REQ_I;
                        end
                    end else begin
                        state_d = S_REQ_D;
                    end
                end
            end
            S_REQ_I, S_REQ_D: begin
                if (!sel_stall) begin
                    rdata_d = wr_q ? '0 : sel_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign stall            = (state_q == S_REQ_I) || (state_q == S_REQ_D);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_err         = (state_q == S_RESP) && err_q;
    assign read_data_L1_C   = rdata_q;
    assign tag_C_L1         = addr_q[ADDR_W-1 -: TAG_W];
    assign index_C_L1       = addr_q[INDEX_W+OFFSET_W-1 -: INDEX_W];
    assign offset           = addr_q[OFFSET_W-1:0];
    assign read_C_L1I       = (state_q == S_REQ_I);
    assign read_C_L1D       = (state_q == S_REQ_D) && !wr_q;
    assign write_C_L1D      = (state_q == S_REQ_D) && wr_q;
    assign write_data_C_L1D = wdata_q;
    assign write_strb_C_L1D = wstrb_q;

endmodule

`default_nettype wire

// File: doc/core_l1_router.md
Name: core_l1_router

Overview:
- Parametrised core-to-L1 request router. Sits between the core memory port and the split L1I/L1D caches.
- Accepts one core request at a time. Splits the address into tag/index/offset and routes the request to L1I or L1D by a configurable address boundary.
- Registers the request, waits on the selected cache's stall, captures the returned data and presents a one-cycle response to the core.
- Adds write support, an error response and a stall timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- OFFSET_W, 6, block offset bits
- INDEX_W, 5, set index bits
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, tag bits
- IMEM_LIMIT, 32'h1000_0000, highest instruction-region address, inclusive
- TIMEOUT, 255, maximum cycles spent waiting on one L1 request; 0 disables the timeout

Ports:
- clk  in  1  clock
- nrst  in  1  reset; synchronous, active-high (1 = reset)
- req_valid  in  1  core request strobe
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  store data
- req_wstrb  in  DATA_W/8  store byte enables
- req_ready  out  1  router can accept a request
- stall  out  1  core must hold the pipeline
- resp_valid  out  1  response valid (one-cycle pulse)
- resp_err  out  1  response is an error
- read_data_L1_C  out  DATA_W  load data returned to the core
- tag_C_L1  out  TAG_W  registered tag
- index_C_L1  out  INDEX_W  registered index
- offset  out  OFFSET_W  registered offset
- read_C_L1I  out  1  read request to L1I
- read_C_L1D  out  1  read request to L1D
- write_C_L1D  out  1  write request to L1D
- write_data_C_L1D  out  DATA_W  registered store data
- write_strb_C_L1D  out  DATA_W/8  registered byte enables
- stall_L1I  in  1  L1I busy
- stall_L1D  in  1  L1D busy
- read_data_L1I_C  in  DATA_W  L1I read data
- read_data_L1D_C  in  DATA_W  L1D read data

Behaviour:
- Reset, synchronous: state = IDLE, timeout counter = 0, all outputs 0 except req_ready = 1. Reset mid-transaction abandons the transaction and no response is issued.
- Region decode: addr <= IMEM_LIMIT selects I; otherwise D. An address exactly equal to IMEM_LIMIT is I.
- FSM states: IDLE, REQ_I, REQ_D, RESP.
- IDLE:
  - req_ready = 1 and stall = 0.
  - On req_valid, register addr/wdata/wstrb/write.
  - Read to I region → REQ_I.
  - Read or write to D region → REQ_D.
  - Write to I region → RESP with resp_err = 1; no cache access.
- REQ_I / REQ_D:
  - Assert read_C_L1I, or read_C_L1D/write_C_L1D, from registered fields. These hold steady for the whole state.
  - stall = 1 and req_ready = 0.
  - Only the selected cache's stall is observed; the other cache's stall is ignored.
  - Completion is the first cycle in this state with the selected stall = 0; this may be the first cycle. On completion, capture the read data (0 for writes) → RESP.
  - Timeout counter increments each cycle the selected stall = 1. If it reaches TIMEOUT → RESP with resp_err = 1 and read_data_L1_C = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - read_data_L1_C and resp_err are valid this cycle. read_data_L1_C holds its value until the next response.
  - stall = 0 and req_ready = 0. Counter clears → IDLE.
- Latency: acceptance edge → REQ_x → RESP. A zero-stall hit gives resp_valid 2 cycles after acceptance. An I-region write error gives resp_valid 1 cycle after acceptance.
- req_valid while req_ready = 0 is ignored; the core must hold or re-present the request.
- Counter width: clog2(TIMEOUT+1); saturation cannot occur.
- Tag/index/offset are the registered address slices [ADDR_W-1 : INDEX_W+OFFSET_W], [INDEX_W+OFFSET_W-1 : OFFSET_W], [OFFSET_W-1 : 0].

Test Plan:
- Reset held 2 cycles with req_valid = 1 → req_ready = 1, all requests and resp_valid = 0, state IDLE.
- Load 0x0000_0040, stall_L1I = 0, read_data_L1I_C = 0xDEAD_BEEF → read_C_L1I = 1 for 1 cycle; resp_valid 2 cycles after acceptance; read_data_L1_C = 0xDEAD_BEEF; tag = 0, index = 1, offset = 0.
- Load 0x1000_0000 → routed to L1I. Load 0x1000_0004 → routed to L1D, with stall_L1D = 1 for 5 cycles then data 0x1234_5678 → stall = 1 for 6 cycles, then resp 0x1234_5678, resp_err = 0.
- Store 0x2000_0000, wdata 0xA5A5_A5A5, wstrb 4'b0011 → write_C_L1D = 1 with registered data and strobes; resp_valid with resp_err = 0. Store to 0x0000_0100 → resp_err = 1 one cycle after acceptance, no cache strobe.
- TIMEOUT = 4, stall_L1D stuck at 1 → resp_err = 1, read_data_L1_C = 0 after 4 stall cycles; stall_L1I toggling during this is ignored.
- Reset asserted in REQ_D mid-stall → next cycle IDLE, no resp_valid; a new request then completes normally.
